// File: rtl/okx_ctrl_pkg.sv
// Shared types, defaults and the saturating-increment helper for the run controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package okx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_REQ,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } run_state_t;

    localparam int          DEF_NUM_PROGS    = 3;
    localparam int          DEF_CNT_W        = 16;
    localparam int unsigned DEF_TIMEOUT      = 32'h0000_FFFF;
    localparam int          DEF_RESET_CYCLES = 2;

    // Increment val, sticking at the all-ones value of a width-bit counter.
    // Operates on a 32-bit carrier so one function serves every counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count updates on the edge after clr/en are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter
    import okx_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Clear has priority over counting; saturation comes from sat_inc.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Program-run sequencer: resets the core, then issues req/awaits halt for each program, timing each.
// Latency: core_reset one cycle after start; next req or done one cycle after halt is seen.
// Backpressure: start is only honoured in IDLE; a watchdog ends a run that never halts.
module run_ctrl
    import okx_ctrl_pkg::*;
#(
    parameter int          NUM_PROGS    = DEF_NUM_PROGS,
    parameter int          CNT_W        = DEF_CNT_W,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter int          RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             core_halt,
    output logic             core_reset,
    output logic             core_req,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [2:0]       prog_idx,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cycles
);

    localparam int               RW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0]    RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_PROGS - 1);

    run_state_t       state;
    logic [RW-1:0]    rst_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rec [NUM_PROGS];
    logic             cnt_clr;
    logic             cnt_en;

    // The counter restarts for every program in REQ and only advances in RUN while the core runs.
    assign cnt_clr = (state == ST_REQ);
    assign cnt_en  = (state == ST_RUN) && !core_halt;
    // Value the record takes if this cycle ends the program (cycles so far including this one).
    assign cnt_inc = CNT_W'(sat_inc(32'(cnt), CNT_W));

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt)
    );

    // Sequencer FSM with registered Moore outputs, fault flag, program index and cycle records.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rst_cnt    <= '0;
            core_reset <= 1'b0;
            core_req   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            prog_idx   <= 3'd0;
            for (int i = 0; i < NUM_PROGS; i++) begin
                rec[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RST;
                        rst_cnt    <= RST_LAST;
                        core_reset <= 1'b1;
                        busy       <= 1'b1;
                        timeout    <= 1'b0;
                        prog_idx   <= 3'd0;
                        for (int i = 0; i < NUM_PROGS; i++) begin
                            rec[i] <= '0;
                        end
                    end
                end
                ST_RST: begin
                    if (rst_cnt == '0) begin
                        state      <= ST_REQ;
                        core_reset <= 1'b0;
                        core_req   <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RW'(1);
                    end
                end
                ST_REQ: begin
                    state    <= ST_ARM;
                    core_req <= 1'b0;
                end
                ST_ARM: begin
                    // A halt still asserted from the previous program is deliberately not looked at here.
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_halt) begin
                        for (int i = 0; i < NUM_PROGS; i++) begin
                            if (prog_idx == 3'(i)) begin
                                rec[i] <= cnt_inc;
                            end
                        end
                        if (prog_idx == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_REQ;
                            core_req <= 1'b1;
                            prog_idx <= prog_idx + 3'd1;
                        end
                    end else if (cnt_inc == TO_VAL) begin
                        for (int i = 0; i < NUM_PROGS; i++) begin
                            if (prog_idx == 3'(i)) begin
                                rec[i] <= TO_VAL;
                            end
                        end
                        state   <= ST_FAULT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    core_reset <= 1'b0;
                    core_req   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency record read; out-of-range selects read as zero.
    always_comb begin
        rd_cycles = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (rd_sel == 3'(i)) begin
                rd_cycles = rec[i];
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: main instance (3 programs, 10-cycle watchdog) and a narrow-counter instance.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: none; every wait is bounded.
module tb_run_ctrl;

    localparam int RC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        core_halt = 1'b0;
    logic        core_reset, core_req, busy, done, timeout;
    logic [2:0]  prog_idx;
    logic [2:0]  rd_sel = 3'd0;
    logic [15:0] rd_cycles;

    logic        s_start = 1'b0;
    logic        s_halt = 1'b0;
    logic        s_core_reset, s_core_req, s_busy, s_done, s_timeout;
    logic [2:0]  s_prog_idx;
    logic [2:0]  s_rd_sel = 3'd0;
    logic [3:0]  s_rd_cycles;

    int checks = 0;
    int failures = 0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    run_ctrl #(.NUM_PROGS(3), .CNT_W(16), .TIMEOUT(10), .RESET_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .start(start), .core_halt(core_halt),
        .core_reset(core_reset), .core_req(core_req), .busy(busy), .done(done),
        .timeout(timeout), .prog_idx(prog_idx), .rd_sel(rd_sel), .rd_cycles(rd_cycles)
    );

    run_ctrl #(.NUM_PROGS(1), .CNT_W(4), .TIMEOUT(15), .RESET_CYCLES(1)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .core_halt(s_halt),
        .core_reset(s_core_reset), .core_req(s_core_req), .busy(s_busy), .done(s_done),
        .timeout(s_timeout), .prog_idx(s_prog_idx), .rd_sel(s_rd_sel), .rd_cycles(s_rd_cycles)
    );

    // Stimulus helpers (no checking inside).
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (core_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the REQ-cycle negedge; leaves halt high in the k-th RUN cycle.
    task automatic drive_halt(input int k, input bit stale);
        if (!stale) core_halt = 1'b0;
        for (int j = 1; j <= k + 1; j++) begin
            @(negedge clk);
            if (j == 2) core_halt = 1'b0;
            if (j == k + 1) core_halt = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({core_reset, core_req, busy, done, timeout} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=00000", {core_reset, core_req, busy, done, timeout}); end
        checks++; if (prog_idx !== 3'd0) begin
            failures++; $display("FAIL reset_prog_idx got=%0d exp=0", prog_idx); end
        checks++; if ({s_core_reset, s_core_req, s_busy, s_done, s_timeout} !== 5'b0) begin
            failures++; $display("FAIL reset_sat_outputs got=%b exp=00000", {s_core_reset, s_core_req, s_busy, s_done, s_timeout}); end
        for (int i = 0; i < 3; i++) sb.push_back(16'd0);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp;
            rd_sel = 3'(i); #1;
            exp = sb.pop_front();
            checks++; if (rd_cycles !== exp) begin
                failures++; $display("FAIL reset_rec%0d got=%0d exp=%0d", i, rd_cycles, exp); end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int dly [3] = '{5, 9, 2};
        pulse_start();
        for (int c = 0; c < RC; c++) begin
            checks++; if (core_reset !== 1'b1 || core_req !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL nominal_rst_c%0d got rst=%b req=%b busy=%b exp 1 0 1", c, core_reset, core_req, busy); end
            @(negedge clk);
        end
        checks++; if (core_req !== 1'b1 || core_reset !== 1'b0) begin
            failures++; $display("FAIL nominal_first_req got req=%b rst=%b exp 1 0", core_req, core_reset); end
        for (int p = 0; p < 3; p++) begin
            sb.push_back(16'(dly[p]));
            drive_halt(dly[p], 1'b0);
            @(negedge clk);
            core_halt = 1'b0;
            if (p < 2) begin
                checks++; if (core_req !== 1'b1 || prog_idx !== 3'(p + 1) || done !== 1'b0) begin
                    failures++; $display("FAIL nominal_req%0d got req=%b idx=%0d done=%b exp 1 %0d 0", p + 1, core_req, prog_idx, done, p + 1); end
            end else begin
                checks++; if (done !== 1'b1 || timeout !== 1'b0 || prog_idx !== 3'd2) begin
                    failures++; $display("FAIL nominal_done got done=%b to=%b idx=%0d exp 1 0 2", done, timeout, prog_idx); end
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || prog_idx !== 3'd2) begin
            failures++; $display("FAIL nominal_idle got done=%b busy=%b idx=%0d exp 0 0 2", done, busy, prog_idx); end
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp;
            rd_sel = 3'(i); #1;
            exp = sb.pop_front();
            checks++; if (rd_cycles !== exp) begin
                failures++; $display("FAIL nominal_rec%0d got=%0d exp=%0d", i, rd_cycles, exp); end
        end
        rd_sel = 3'd5; #1;
        checks++; if (rd_cycles !== 16'd0) begin
            failures++; $display("FAIL nominal_rd_oob got=%0d exp=0", rd_cycles); end
        @(negedge clk);
    endtask

    task automatic test_stale_halt();
        int dly [3] = '{3, 5, 4};
        bit stl [3] = '{1'b0, 1'b1, 1'b1};
        bit ok;
        pulse_start();
        wait_req(ok);
        checks++; if (!ok) begin
            failures++; $display("FAIL stale_wait_req got=timeout exp=req"); end
        for (int p = 0; p < 3; p++) begin
            sb.push_back(16'(dly[p]));
            drive_halt(dly[p], stl[p]);
            @(negedge clk);
            if (p < 2) begin
                checks++; if (core_req !== 1'b1) begin
                    failures++; $display("FAIL stale_req%0d got=%b exp=1", p + 1, core_req); end
            end else begin
                checks++; if (done !== 1'b1 || timeout !== 1'b0) begin
                    failures++; $display("FAIL stale_done got done=%b to=%b exp 1 0", done, timeout); end
            end
        end
        core_halt = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp;
            rd_sel = 3'(i); #1;
            exp = sb.pop_front();
            checks++; if (rd_cycles !== exp) begin
                failures++; $display("FAIL stale_rec%0d got=%0d exp=%0d", i, rd_cycles, exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        bit ok;
        core_halt = 1'b0;
        pulse_start();
        wait_req(ok);
        checks++; if (!ok) begin
            failures++; $display("FAIL wd_wait_req got=timeout exp=req"); end
        repeat (11) @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
            failures++; $display("FAIL wd_run10 got done=%b busy=%b to=%b exp 0 1 0", done, busy, timeout); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || timeout !== 1'b1 || prog_idx !== 3'd0) begin
            failures++; $display("FAIL wd_fault got done=%b to=%b idx=%0d exp 1 1 0", done, timeout, prog_idx); end
        repeat (4) @(negedge clk);
        checks++; if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL wd_sticky got to=%b busy=%b done=%b exp 1 0 0", timeout, busy, done); end
        sb.push_back(16'd10); sb.push_back(16'd0); sb.push_back(16'd0);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp;
            rd_sel = 3'(i); #1;
            exp = sb.pop_front();
            checks++; if (rd_cycles !== exp) begin
                failures++; $display("FAIL wd_rec%0d got=%0d exp=%0d", i, rd_cycles, exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bit ok;
        pulse_start();
        checks++; if (timeout !== 1'b0 || prog_idx !== 3'd0) begin
            failures++; $display("FAIL sim_start_clears got to=%b idx=%0d exp 0 0", timeout, prog_idx); end
        wait_req(ok);
        checks++; if (!ok) begin
            failures++; $display("FAIL sim_wait_req got=timeout exp=req"); end
        sb.push_back(16'd10);
        drive_halt(10, 1'b0);
        @(negedge clk);
        core_halt = 1'b0;
        checks++; if (core_req !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            failures++; $display("FAIL sim_halt_wins got req=%b done=%b to=%b exp 1 0 0", core_req, done, timeout); end
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || core_reset !== 1'b0 || core_req !== 1'b0 || prog_idx !== 3'd1 || done !== 1'b0) begin
            failures++; $display("FAIL sim_start_busy got busy=%b rst=%b req=%b idx=%0d done=%b exp 1 0 0 1 0",
                busy, core_reset, core_req, prog_idx, done); end
        repeat (2) @(negedge clk);
        core_halt = 1'b1;
        sb.push_back(16'd4);
        @(negedge clk);
        core_halt = 1'b0;
        checks++; if (core_req !== 1'b1 || prog_idx !== 3'd2) begin
            failures++; $display("FAIL sim_req2 got req=%b idx=%0d exp 1 2", core_req, prog_idx); end
        sb.push_back(16'd1);
        drive_halt(1, 1'b0);
        @(negedge clk);
        core_halt = 1'b0;
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin
            failures++; $display("FAIL sim_done got done=%b to=%b exp 1 0", done, timeout); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp;
            rd_sel = 3'(i); #1;
            exp = sb.pop_front();
            checks++; if (rd_cycles !== exp) begin
                failures++; $display("FAIL sim_rec%0d got=%0d exp=%0d", i, rd_cycles, exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        pulse_start();
        wait_req(ok);
        checks++; if (!ok) begin
            failures++; $display("FAIL rstmid_wait_req got=timeout exp=req"); end
        drive_halt(2, 1'b0);
        @(negedge clk);
        core_halt = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({core_reset, core_req, busy, done, timeout} !== 5'b0 || prog_idx !== 3'd0) begin
            failures++; $display("FAIL rstmid_outputs got=%b idx=%0d exp=00000 0", {core_reset, core_req, busy, done, timeout}, prog_idx); end
        for (int i = 0; i < 3; i++) sb.push_back(16'd0);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp;
            rd_sel = 3'(i); #1;
            exp = sb.pop_front();
            checks++; if (rd_cycles !== exp) begin
                failures++; $display("FAIL rstmid_rec%0d got=%0d exp=%0d", i, rd_cycles, exp); end
        end
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        for (int c = 0; c < RC; c++) begin
            checks++; if (core_reset !== 1'b1 || prog_idx !== 3'd0) begin
                failures++; $display("FAIL rstmid_restart_rst_c%0d got rst=%b idx=%0d exp 1 0", c, core_reset, prog_idx); end
            @(negedge clk);
        end
        checks++; if (core_req !== 1'b1) begin
            failures++; $display("FAIL rstmid_restart_req got=%b exp=1", core_req); end
        for (int p = 0; p < 3; p++) begin
            sb.push_back(16'd1);
            drive_halt(1, 1'b0);
            @(negedge clk);
            core_halt = 1'b0;
        end
        checks++; if (done !== 1'b1) begin
            failures++; $display("FAIL rstmid_done got=%b exp=1", done); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp;
            rd_sel = 3'(i); #1;
            exp = sb.pop_front();
            checks++; if (rd_cycles !== exp) begin
                failures++; $display("FAIL rstmid_rerun_rec%0d got=%0d exp=%0d", i, rd_cycles, exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [15:0] exp;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        checks++; if (s_core_reset !== 1'b1 || s_core_req !== 1'b0) begin
            failures++; $display("FAIL sat_rst got rst=%b req=%b exp 1 0", s_core_reset, s_core_req); end
        @(negedge clk);
        checks++; if (s_core_req !== 1'b1 || s_core_reset !== 1'b0) begin
            failures++; $display("FAIL sat_req got req=%b rst=%b exp 1 0", s_core_req, s_core_reset); end
        sb.push_back(16'd15);
        repeat (16) @(negedge clk);
        s_halt = 1'b1;
        @(negedge clk);
        s_halt = 1'b0;
        checks++; if (s_done !== 1'b1 || s_timeout !== 1'b0) begin
            failures++; $display("FAIL sat_done got done=%b to=%b exp 1 0", s_done, s_timeout); end
        s_rd_sel = 3'd0; #1;
        exp = sb.pop_front();
        checks++; if (16'(s_rd_cycles) !== exp) begin
            failures++; $display("FAIL sat_rec0 got=%0d exp=%0d", s_rd_cycles, exp); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired exp=finish");
        $fatal(1, "time limit");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_stale_halt();
        test_watchdog();
        test_simultaneous();
        test_reset_mid_run();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Program-run sequencer for the OKX core. On a single `start` pulse it resets the core, then issues one `req` pulse per program and waits for `halt`, for `NUM_PROGS` programs back-to-back. It records the per-program cycle count, with a saturating counter and a watchdog timeout. It sits above the top-level core: it drives the core's `reset` and `req` and observes its `halt`.

## Interface
- `NUM_PROGS`, default 3: programs run per `start`, range 1..8.
- `CNT_W`, default 16: cycle-counter width.
- `TIMEOUT`, default 16'hFFFF: RUN cycles allowed per program before fault, range 2..2^CNT_W-1.
- `RESET_CYCLES`, default 2: cycles `core_reset` is held at the start of a sequence, minimum 1.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- `core_halt`  in  1  `halt` from the core.
- `core_reset`  out  1  drives the core's `reset`.
- `core_req`  out  1  drives the core's `req`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at sequence end, on success or fault.
- `timeout`  out  1  sticky fault flag; cleared by an accepted `start` or by `reset`.
- `prog_idx`  out  3  index of the current or last program.
- `rd_sel`  in  3  selects the cycle-record register to read.
- `rd_cycles`  out  CNT_W  combinational read of record[`rd_sel`]; reads 0 when `rd_sel` ≥ NUM_PROGS.

## Operation
- States:
  - IDLE
  - RST: `core_reset`=1
  - REQ: `core_req`=1
  - ARM
  - RUN
  - DONE
  - FAULT
- Outputs are Moore-decoded from the registered state; `timeout`, `prog_idx` and the records are registers.
- IDLE → RST on `start`.
  - Accepting `start` clears `timeout`, `prog_idx` and all records to 0.
  - `start` in any other state is ignored.
- RST lasts exactly RESET_CYCLES cycles, then → REQ.
- REQ lasts 1 cycle, then → ARM. The counter is cleared to 0 on REQ entry.
- ARM lasts 1 cycle, then → RUN. `core_halt` is ignored here, because a stale halt from the previous program may still be asserted.
- RUN: the counter increments, saturating at all-ones, every cycle in which `core_halt`=0.
  - On `core_halt`=1, record[`prog_idx`] ← counter+1, saturated.
    - If `prog_idx`=NUM_PROGS-1, go to DONE.
    - Otherwise increment `prog_idx` and go to REQ. The core is not reset between programs.
  - If `core_halt`=0 and counter+1 = TIMEOUT, set record ← TIMEOUT, set `timeout`←1, and go to FAULT.
  - Halt and the timeout cycle coinciding: halt wins.
- DONE and FAULT each last 1 cycle with `done`=1, then → IDLE. `prog_idx` holds its final value.
- Reset values:
  - state IDLE
  - `core_reset`=0
  - `core_req`=0
  - `busy`=0
  - `done`=0
  - `timeout`=0
  - `prog_idx`=0
  - counter 0, all records 0
- `reset` asserted in any state returns to IDLE on the next edge. Any partial record is discarded; the records are zeroed.

## Timing
- `start` sampled high at edge 0: `core_reset`=1 during cycles 1..RESET_CYCLES, and `core_req`=1 in cycle RESET_CYCLES+1.
- Per program, the recorded value is the number of RUN cycles up to and including the cycle in which halt is seen.
- Halt sampled high in RUN at cycle t:
  - The next program's `core_req` is in cycle t+1.
  - For the last program, `done` is in cycle t+1.
- Minimum gap between successive `core_req` pulses is 3 cycles (REQ, ARM, one RUN cycle).
- `rd_cycles` has zero latency and reflects a record update from the edge that writes it.

## Structure
- Shared package `okx_ctrl_pkg`:
  - `run_state_t` enum
  - default parameter constants
  - the `sat_inc` function used for the saturating CNT_W increment
- One sub-module: `sat_counter`, a CNT_W saturating counter with `clr` and `en`, instantiated once.
- The record array is a NUM_PROGS×CNT_W register file inside `run_ctrl`.

## Test plan
- Nominal run (NUM_PROGS=3): after `start`, core model halts 5, 9 and 2 RUN cycles after each `req` → records read 5, 9, 2; three `core_req` pulses; `done` one cycle after the third halt; `timeout`=0.
- Stale halt: `core_halt` held high through REQ and ARM, then low for 4 cycles, then high → record = 5; the stale halt is not counted.
- Watchdog (TIMEOUT=10): no halt → FAULT after 10 RUN cycles; `timeout`=1 and `done` pulse; record[0]=10; `timeout` stays set until the next `start`.
- Simultaneous events: halt on the 10th RUN cycle with TIMEOUT=10 → success path, `timeout`=0. `start` asserted while busy → no effect on state or outputs.
- Reset mid-RUN of program 1 → next cycle IDLE, all outputs at reset values, records 0. A following `start` restarts from program 0 with RESET_CYCLES of `core_reset`.
- Saturation (CNT_W=4, TIMEOUT=15): halt on the 15th cycle → record=15, no wrap to 0.
